// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: E-stage op codes, sequencer states,
// and small op-class helpers used by the decoder and the MDU.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for a mul/div op
// and flags a zero divisor so the sequencer can leave HI/LO untouched.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic               is_signed;
  logic signed [63:0] a64;
  logic signed [63:0] b64;
  logic signed [32:0] a33;
  logic signed [32:0] b33;

  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    div_zero  = is_div(op) && (in2 == 32'd0);
    a64       = is_signed ? {{32{in1[31]}}, in1} : {32'd0, in1};
    b64       = is_signed ? {{32{in2[31]}}, in2} : {32'd0, in2};
    // 33-bit operands keep -2^31 / -1 representable; the zero divisor is swapped for 1
    a33       = {is_signed & in1[31], in1};
    b33       = div_zero ? 33'sd1 : {is_signed & in2[31], in2};
    hi_res    = 32'd0;
    lo_res    = 32'd0;
    if (is_div(op)) begin
      lo_res = 32'(a33 / b33);
      hi_res = 32'(a33 % b33);
    end else if (is_muldiv(op)) begin
      {hi_res, lo_res} = a64 * b64;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: latches the result at start,
// counts out the fixed latency, commits, and stalls D-stage MD users meanwhile.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        req,
  input  logic        d_md,
  output logic [31:0] rd_out,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_op_e      op;
  mdu_state_e  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] pend_hi_reg, pend_lo_reg;
  logic        pend_wr_reg;
  logic [31:0] hi_res, lo_res;
  logic        div_zero;
  logic        start;
  logic        commit;

  assign op     = md_op_e'(md_op);
  assign start  = (state_reg == ST_IDLE) && is_muldiv(op) && !req;
  assign commit = (state_reg == ST_RUN) && (cnt_reg == 4'd0);

  mdu_arith u_arith (
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          cnt_next   = is_div(op) ? DIV_LOAD : MULT_LOAD;
        end
      end
      ST_RUN: begin
        if (cnt_reg == 4'd0) state_next = ST_IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of register contents
  always_comb begin
    busy     = reset && (state_reg == ST_RUN);
    md_stall = reset && d_md && ((state_reg == ST_RUN) || start);
    rd_out   = 32'd0;
    if (reset) begin
      if (op == MD_MFHI)      rd_out = hi_reg;
      else if (op == MD_MFLO) rd_out = lo_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
    end else begin
      if (start) begin
        pend_hi_reg <= hi_res;
        pend_lo_reg <= lo_res;
        pend_wr_reg <= !div_zero;
      end
      if (commit) begin
        if (pend_wr_reg) begin
          hi_reg <= pend_hi_reg;
          lo_reg <= pend_lo_reg;
        end
      end else if (!req) begin
        if (op == MD_MTHI) hi_reg <= in1;
        if (op == MD_MTLO) lo_reg <= in1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed literal checks plus randomized traffic compared every
// cycle against a cycle-count/arithmetic reference model of HI/LO and the busy window.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        req = 1'b0;
  logic        d_md = 1'b0;
  logic [31:0] rd_out;
  logic        busy;
  logic        md_stall;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .in1      (in1),
    .in2      (in2),
    .req      (req),
    .d_md     (d_md),
    .rd_out   (rd_out),
    .busy     (busy),
    .md_stall (md_stall)
  );

  // Reference model state: architectural HI/LO plus the edge index at which the op commits
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pwr = 0, m_run = 0, m_valid = 0;
  int          m_commit = 0;
  int          ecount = 0;

  function automatic bit is_md(logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic [63:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = sa * sb; return p; end
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIV:   return {32'(sa % sb), 32'(sa / sb)};
      default:  return {a % b, a / b};
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [63:0] r;
    bit          committed;
    ecount++;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_run = 0;
      m_valid = 1;
    end else begin
      committed = 0;
      if (m_run && ecount == m_commit) begin
        if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
        m_run = 0;
        committed = 1;
      end else if (!m_run && is_md(md_op) && !req) begin
        if (in2 == 0 && (md_op == MD_DIV || md_op == MD_DIVU)) begin
          m_pwr = 0;
        end else begin
          r = ref_result(md_op, in1, in2);
          m_phi = r[63:32];
          m_plo = r[31:0];
          m_pwr = 1;
        end
        m_run = 1;
        m_commit = ecount + ((md_op == MD_DIV || md_op == MD_DIVU) ? DC : MC);
      end
      if (!req && !committed) begin
        if (md_op == MD_MTHI) m_hi = in1;
        if (md_op == MD_MTLO) m_lo = in1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        e_busy, e_stall, start_now;
    logic [31:0] e_rd;
    if (m_valid) begin
      start_now = !m_run && is_md(md_op) && !req;
      e_busy    = reset && m_run;
      e_stall   = reset && d_md && (m_run || start_now);
      e_rd      = 32'd0;
      if (reset && md_op == MD_MFHI) e_rd = m_hi;
      if (reset && md_op == MD_MFLO) e_rd = m_lo;
      check("model_busy", {31'd0, busy}, {31'd0, e_busy});
      check("model_stall", {31'd0, md_stall}, {31'd0, e_stall});
      check("model_rd_out", rd_out, e_rd);
    end
  end

  // One cycle per call: inputs change 2 time units after the edge, then wait for the sample point
  task automatic setin(input logic rst, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq, input logic dm);
    @(posedge clk);
    #2;
    reset = rst; md_op = op; in1 = a; in2 = b; req = rq; d_md = dm;
    @(negedge clk);
    $display("cyc=%0d rst=%b op=%0d in1=%h in2=%h req=%b d_md=%b -> rd_out=%h busy=%b stall=%b",
             ecount, rst, op, a, b, rq, dm, rd_out, busy, md_stall);
  endtask

  int n;

  initial begin
    setin(0, MD_NONE, 0, 0, 0, 1);
    setin(0, MD_MFHI, 0, 0, 0, 1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, md_stall}, 32'd0);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("reset_hi", rd_out, 32'd0);
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("reset_lo", rd_out, 32'd0);

    n = 0;
    setin(1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 1);
    n += int'(md_stall);
    repeat (5) begin setin(1, MD_NONE, 0, 0, 0, 1); n += int'(md_stall); end
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("mult_stall_cycles", n, 6);
    check("mult_lo", rd_out, 32'hFFFF_FFFA);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("mult_hi", rd_out, 32'hFFFF_FFFF);

    n = 0;
    setin(1, MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0);
    repeat (5) begin setin(1, MD_NONE, 0, 0, 0, 0); n += int'(busy); end
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("multu_busy_cycles", n, 5);
    check("multu_hi", rd_out, 32'h0000_0002);
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("multu_lo", rd_out, 32'hFFFF_FFFA);

    n = 0;
    setin(1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    repeat (10) begin setin(1, MD_NONE, 0, 0, 0, 0); n += int'(busy); end
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("div_busy_cycles", n, 10);
    check("div_lo", rd_out, 32'hFFFF_FFFD);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("div_hi", rd_out, 32'hFFFF_FFFF);

    n = 0;
    setin(1, MD_DIVU, 32'd7, 32'd0, 0, 0);
    repeat (10) begin setin(1, MD_NONE, 0, 0, 0, 0); n += int'(busy); end
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("divz_busy_cycles", n, 10);
    check("divz_lo", rd_out, 32'hFFFF_FFFD);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("divz_hi", rd_out, 32'hFFFF_FFFF);

    setin(1, MD_MULT, 32'd5, 32'd7, 1, 0);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("req_mult_busy", {31'd0, busy}, 32'd0);
    check("req_mult_hi", rd_out, 32'hFFFF_FFFF);
    setin(1, MD_MTLO, 32'h1234, 0, 1, 0);
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("req_mtlo_lo", rd_out, 32'hFFFF_FFFD);

    setin(1, MD_MTHI, 32'hABCD, 0, 0, 0);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("mthi_hi", rd_out, 32'h0000_ABCD);

    setin(1, MD_MULT, 32'd5, 32'd7, 0, 0);
    setin(1, MD_NONE, 0, 0, 0, 0);
    setin(0, MD_NONE, 0, 0, 0, 0);
    setin(1, MD_MFHI, 0, 0, 0, 0);
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_hi", rd_out, 32'd0);
    n = 0;
    repeat (4) begin setin(1, MD_NONE, 0, 0, 0, 0); n += int'(busy); end
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("rst_run_no_busy", n, 0);
    check("rst_run_lo", rd_out, 32'd0);

    setin(1, MD_MULT, 32'd5, 32'd7, 0, 0);
    repeat (5) setin(1, MD_NONE, 0, 0, 0, 0);
    setin(1, MD_MFLO, 0, 0, 0, 0);
    check("post_rst_mult_lo", rd_out, 32'd35);

    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_req, r_dm;
      logic [3:0]  r_op;
      logic [31:0] r_a, r_b;
      r_rst = ($urandom % 64) != 0;
      r_op  = 4'($urandom % 9);
      if (m_run && (r_op == MD_MTHI || r_op == MD_MTLO)) r_op = MD_NONE;
      r_a   = $urandom;
      r_b   = (($urandom % 6) == 0) ? 32'd0 : $urandom;
      if (($urandom % 20) == 0) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      r_req = ($urandom % 8) == 0;
      r_dm  = $urandom % 2;
      setin(r_rst, r_op, r_a, r_b, r_req, r_dm);
    end
    setin(1, MD_NONE, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
